// File: rtl/comparator_pkg.sv
// ---------------------------------------------------------------------------
// comparator_pkg
//   Shared definitions for the pipelined magnitude comparator.
//   - One-hot result encodings, ordered {gt, eq, lt}.
//   - num_slices(): the pipeline depth for a given operand and slice width.
// ---------------------------------------------------------------------------
package comparator_pkg;

  // One-hot result encodings, bit order {gt, eq, lt}
  localparam logic [2:0] CMP_GT   = 3'b100;
  localparam logic [2:0] CMP_EQ   = 3'b010;
  localparam logic [2:0] CMP_LT   = 3'b001;
  localparam logic [2:0] CMP_NONE = 3'b000;

  // Number of slice stages needed to consume a dw-bit operand sw bits at a time.
  // A zero slice width yields zero so that the parameter check reports the error.
  function automatic int num_slices(input int dw, input int sw);
    if (sw <= 0) begin
      return 0;
    end
    return dw / sw;
  endfunction

endpackage : comparator_pkg

// File: rtl/cmp_slice_stage.sv
// ---------------------------------------------------------------------------
// cmp_slice_stage
//   One register stage of the pipelined comparator.
//   It compares the top SLICE_WIDTH bits of the operand bits it receives,
//   merges the result with the upstream decision, and stores the bits that
//   are still unconsumed for the next stage.
//
//   Parameters
//     SLICE_WIDTH  bits compared in this stage
//     IN_BITS      operand bits entering this stage (this slice + remainder)
//
//   Ports
//     clk, rst_n          clock, asynchronous active-low reset
//     in_valid            upstream stage (or input port) holds a transaction
//     in_decided          upstream already found a differing slice
//     in_gt, in_lt        upstream decision (meaningful when in_decided = 1)
//     in_a, in_b          unconsumed operand bits, this slice in the MSBs
//     down_ready          downstream can take this stage's content
//     up_ready            this stage can take a new transaction
//     valid               this stage holds a transaction
//     decided, gt, lt     merged decision so far
//     rem_a, rem_b        operand bits left for later stages (zero when none)
// ---------------------------------------------------------------------------
module cmp_slice_stage
  import comparator_pkg::*;
#(
  parameter  int SLICE_WIDTH = 8,
  parameter  int IN_BITS     = 32,
  localparam int REM_BITS    = IN_BITS - SLICE_WIDTH,
  // keep the remainder ports at least one bit wide for the last stage
  localparam int REM_W       = (REM_BITS > 0) ? REM_BITS : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic               in_decided,
  input  logic               in_gt,
  input  logic               in_lt,
  input  logic [IN_BITS-1:0] in_a,
  input  logic [IN_BITS-1:0] in_b,
  input  logic               down_ready,
  output logic               up_ready,
  output logic               valid,
  output logic               decided,
  output logic               gt,
  output logic               lt,
  output logic [REM_W-1:0]   rem_a,
  output logic [REM_W-1:0]   rem_b
);

  logic [SLICE_WIDTH-1:0] slice_a;
  logic [SLICE_WIDTH-1:0] slice_b;
  logic                   decided_next;
  logic                   gt_next;
  logic                   lt_next;

  assign slice_a = in_a[IN_BITS-1 -: SLICE_WIDTH];
  assign slice_b = in_b[IN_BITS-1 -: SLICE_WIDTH];

  // An empty stage always accepts; a full one only when its content moves on.
  assign up_ready = ~valid | down_ready;

  // Once a more significant slice has differed, lower slices cannot change
  // the outcome, so the upstream decision is passed through untouched.
  always_comb begin
    decided_next = in_decided;
    gt_next      = in_gt;
    lt_next      = in_lt;
    if (!in_decided) begin
      decided_next = (slice_a != slice_b);
      gt_next      = (slice_a > slice_b);
      lt_next      = (slice_a < slice_b);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid   <= 1'b0;
      decided <= 1'b0;
      gt      <= 1'b0;
      lt      <= 1'b0;
    end else if (up_ready) begin
      valid <= in_valid;
      // Payload only changes when a real transaction arrives, so empty
      // stages do not toggle on bubbles.
      if (in_valid) begin
        decided <= decided_next;
        gt      <= gt_next;
        lt      <= lt_next;
      end
    end
  end

  generate
    if (REM_BITS > 0) begin : g_rem
      logic [REM_W-1:0] rem_a_reg;
      logic [REM_W-1:0] rem_b_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rem_a_reg <= '0;
          rem_b_reg <= '0;
        end else if (up_ready && in_valid) begin
          rem_a_reg <= in_a[REM_W-1:0];
          rem_b_reg <= in_b[REM_W-1:0];
        end
      end

      assign rem_a = rem_a_reg;
      assign rem_b = rem_b_reg;
    end else begin : g_no_rem
      // Last stage: every operand bit has been consumed.
      assign rem_a = '0;
      assign rem_b = '0;
    end
  endgenerate

endmodule : cmp_slice_stage

// File: rtl/comparator_pipe.sv
// ---------------------------------------------------------------------------
// comparator_pipe
//   Pipelined magnitude comparator with valid/ready handshakes on both sides.
//   Operands are compared SLICE_WIDTH bits per stage, most significant slice
//   first; the last stage drives one-hot gt/eq/lt flags.
//
//   Parameters
//     DATA_WIDTH   operand width, an integer multiple of SLICE_WIDTH
//     SLICE_WIDTH  bits compared per stage (1..DATA_WIDTH)
//
//   Ports
//     clk, rst_n      clock, asynchronous active-low reset
//     in_valid        operand pair presented
//     in_ready        operands accepted this cycle (independent of in_valid)
//     a_in, b_in      operands
//     signed_in       1: two's-complement compare, 0: unsigned
//     out_valid       result presented
//     out_ready       consumer takes the result this cycle
//     a_gt_b_out      A > B  (0 when out_valid = 0)
//     a_eq_b_out      A == B (0 when out_valid = 0)
//     a_lt_b_out      A < B  (0 when out_valid = 0)
// ---------------------------------------------------------------------------
module comparator_pipe
  import comparator_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SLICE_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  input  logic                  signed_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  a_gt_b_out,
  output logic                  a_eq_b_out,
  output logic                  a_lt_b_out
);

  localparam int NUM_SLICES = num_slices(DATA_WIDTH, SLICE_WIDTH);

  generate
    if ((SLICE_WIDTH < 1) || (SLICE_WIDTH > DATA_WIDTH) ||
        ((DATA_WIDTH % SLICE_WIDTH) != 0)) begin : g_bad_params
      $error("comparator_pipe: DATA_WIDTH (%0d) must be a positive multiple of SLICE_WIDTH (%0d)",
             DATA_WIDTH, SLICE_WIDTH);
    end
  endgenerate

  // Signed compare via offset binary: flipping both MSBs maps two's-complement
  // order onto unsigned order, so every stage can stay a plain unsigned compare.
  logic [DATA_WIDTH-1:0] msb_flip;
  logic [DATA_WIDTH-1:0] a_biased;
  logic [DATA_WIDTH-1:0] b_biased;

  assign msb_flip = DATA_WIDTH'(signed_in) << (DATA_WIDTH - 1);
  assign a_biased = a_in ^ msb_flip;
  assign b_biased = b_in ^ msb_flip;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLICES; gi++) begin : g_stage
      localparam int IN_BITS = DATA_WIDTH - gi * SLICE_WIDTH;
      localparam int REM_W   = (IN_BITS > SLICE_WIDTH) ? (IN_BITS - SLICE_WIDTH) : 1;

      logic [IN_BITS-1:0] cur_a;
      logic [IN_BITS-1:0] cur_b;
      logic               cur_valid;
      logic               cur_decided;
      logic               cur_gt;
      logic               cur_lt;
      logic               down_ready;
      logic               up_ready;
      logic               valid;
      logic               decided;
      logic               gt;
      logic               lt;
      logic [REM_W-1:0]   rem_a;
      logic [REM_W-1:0]   rem_b;

      // Stage inputs: the ports for the head, the previous stage otherwise.
      if (gi == 0) begin : g_head
        assign cur_a       = a_biased;
        assign cur_b       = b_biased;
        assign cur_valid   = in_valid;
        assign cur_decided = 1'b0;
        assign cur_gt      = 1'b0;
        assign cur_lt      = 1'b0;
      end else begin : g_body
        assign cur_a       = g_stage[gi-1].rem_a;
        assign cur_b       = g_stage[gi-1].rem_b;
        assign cur_valid   = g_stage[gi-1].valid;
        assign cur_decided = g_stage[gi-1].decided;
        assign cur_gt      = g_stage[gi-1].gt;
        assign cur_lt      = g_stage[gi-1].lt;
      end

      // Ready chain: runs combinationally from out_ready back to in_ready.
      if (gi == NUM_SLICES - 1) begin : g_tail
        assign down_ready = ~out_valid | out_ready;
      end else begin : g_link
        assign down_ready = g_stage[gi+1].up_ready;
      end

      cmp_slice_stage #(
        .SLICE_WIDTH (SLICE_WIDTH),
        .IN_BITS     (IN_BITS)
      ) u_stage (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (cur_valid),
        .in_decided (cur_decided),
        .in_gt      (cur_gt),
        .in_lt      (cur_lt),
        .in_a       (cur_a),
        .in_b       (cur_b),
        .down_ready (down_ready),
        .up_ready   (up_ready),
        .valid      (valid),
        .decided    (decided),
        .gt         (gt),
        .lt         (lt),
        .rem_a      (rem_a),
        .rem_b      (rem_b)
      );
    end
  endgenerate

  assign in_ready  = g_stage[0].up_ready;
  assign out_valid = g_stage[NUM_SLICES-1].valid;

  // The last stage's remainder is always zero and has no consumer.
  logic unused_tail_rem;
  assign unused_tail_rem = ^{g_stage[NUM_SLICES-1].rem_a, g_stage[NUM_SLICES-1].rem_b};

  logic       last_decided;
  logic       last_gt;
  logic       last_lt;
  logic [2:0] flags;

  assign last_decided = g_stage[NUM_SLICES-1].decided;
  assign last_gt      = g_stage[NUM_SLICES-1].gt;
  assign last_lt      = g_stage[NUM_SLICES-1].lt;

  // Never-decided means every slice matched. Flags are forced low whenever
  // no result is presented.
  always_comb begin
    flags = CMP_NONE;
    if (out_valid) begin
      if (!last_decided) begin
        flags = CMP_EQ;
      end else if (last_gt) begin
        flags = CMP_GT;
      end else if (last_lt) begin
        flags = CMP_LT;
      end
    end
  end

  assign {a_gt_b_out, a_eq_b_out, a_lt_b_out} = flags;

endmodule : comparator_pipe
